// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and constants for the reset sequencer.
// Holds the FSM state enum, a clog2 helper and default timing values.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT,
        DONE
    } state_t;

    localparam int DEF_DELAY   = 4096;
    localparam int DEF_TIMEOUT = 65536;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases CH_NUM reset lines in order after initial_done,
// each after DELAY cycles, optionally gated by ch_ack with a TIMEOUT.
// Ports: clk, rst (sync, active-high), initial_done, soft_req, ch_ack,
//        reset_out (1 = released), seq_done, timeout_err (sticky), cur_ch.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int DELAY   = DEF_DELAY,
    parameter int ACK_EN  = 0,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int HW = (clog2(CH_NUM) < 1) ? 1 : clog2(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              initial_done,
    input  logic              soft_req,
    input  logic [CH_NUM-1:0] ch_ack,
    output logic [CH_NUM-1:0] reset_out,
    output logic              seq_done,
    output logic              timeout_err,
    output logic [HW-1:0]     cur_ch
);

    localparam int MAXV = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
    localparam int CW   = (clog2(MAXV) < 1) ? 1 : clog2(MAXV);

    localparam logic [CW-1:0]     D_LAST  = CW'(DELAY - 1);
    localparam logic [CW-1:0]     T_LAST  = CW'(TIMEOUT - 1);
    localparam logic [HW-1:0]     LAST_CH = HW'(CH_NUM - 1);
    localparam logic [CH_NUM-1:0] ONE     = CH_NUM'(1);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [HW-1:0]       cur_n;
    logic [CH_NUM-1:0]   rout_n;
    logic                done_n;
    logic                err_n;
    logic                adv;
    logic                ack_cur;

    // Mask-based select avoids out-of-range indexing for odd CH_NUM.
    assign ack_cur = |(ch_ack & (ONE << cur_ch));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_ch      <= '0;
            reset_out   <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur_ch      <= cur_n;
            reset_out   <= rout_n;
            seq_done    <= done_n;
            timeout_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur_ch;
        rout_n  = reset_out;
        done_n  = seq_done;
        err_n   = timeout_err;
        adv     = 1'b0;

        if (!initial_done) begin
            // Abort: everything back to reset, error flag kept.
            state_n = IDLE;
            cnt_n   = '0;
            cur_n   = '0;
            rout_n  = '0;
            done_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = HOLD;
                end
                HOLD: begin
                    if (cnt == D_LAST) begin
                        rout_n = reset_out | (ONE << cur_ch);
                        cnt_n  = '0;
                        if (ACK_EN != 0)
                            state_n = WAIT;
                        else
                            adv = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (ack_cur) begin
                        adv = 1'b1;
                    end else if (cnt == T_LAST) begin
                        err_n = 1'b1;
                        adv   = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (soft_req) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                        cur_n   = '0;
                        rout_n  = '0;
                        done_n  = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase

            // Step to the next channel, or finish after the last one.
            if (adv) begin
                cnt_n = '0;
                if (cur_ch == LAST_CH) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cur_n   = cur_ch + HW'(1);
                    state_n = HOLD;
                end
            end
        end
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised, multi-channel successor to the single-output post-initialisation reset release. After `initial_done` rises it releases `CH_NUM` downstream reset lines one at a time, each after a programmable hold-off. An optional per-channel acknowledge with a timeout gates each step. A soft re-sequence request and a sticky error flag complete the block. It sits between the board-initialisation logic and the USB, DDR3 and SDHC interface blocks, so each interface starts only after its predecessor is up.

## Interface
Parameters:
- `CH_NUM`, 4: number of sequenced reset outputs (1..16).
- `DELAY`, 4096: hold-off cycles before each channel release (≥1).
- `ACK_EN`, 0: 1 = wait for `ch_ack[i]` after releasing channel i; 0 = time-based only.
- `TIMEOUT`, 65536: maximum wait cycles for an acknowledge when `ACK_EN`=1 (≥1).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; overrides every other input.
- `initial_done`  in  1  level; 1 = board initialisation complete; 0 aborts and holds everything in reset.
- `soft_req`  in  1  single-cycle pulse; re-runs the whole sequence (honoured only in DONE).
- `ch_ack`  in  CH_NUM  per-channel "up" level from each downstream block; ignored when `ACK_EN`=0.
- `reset_out`  out  CH_NUM  bit i: 0 = channel i held in reset, 1 = released (same polarity as the existing USB reset release).
- `seq_done`  out  1  1 while every channel is released.
- `timeout_err`  out  1  sticky; set when any acknowledge times out.
- `cur_ch`  out  clog2(CH_NUM) (min 1)  index of the channel currently being sequenced.

## Operation
- A single counter `cnt` is shared. Its width is clog2(max(DELAY, TIMEOUT)). The counter is an unsigned value that never wraps: it is cleared before it reaches its terminal value.
- State IDLE: all outputs 0; `cnt`=0, `cur_ch`=0. On `initial_done`=1, go to HOLD.
- State HOLD: increment `cnt` each cycle. When `cnt`==DELAY-1:
  - set `reset_out[cur_ch]`=1 and clear `cnt`;
  - if `ACK_EN`, go to WAIT;
  - else if `cur_ch`==CH_NUM-1, go to DONE;
  - else increment `cur_ch` and stay in HOLD.
- State WAIT: each cycle, on the first matching condition:
  - `ch_ack[cur_ch]`=1: advance as in HOLD (go to DONE if last channel, else increment `cur_ch`, clear `cnt`, go to HOLD);
  - `cnt`==TIMEOUT-1: set `timeout_err`, then advance the same way;
  - otherwise increment `cnt`.
- State DONE: `seq_done`=1. When `soft_req`=1: clear all `reset_out` bits, `seq_done`, `cur_ch` and `cnt`, then go to HOLD. `timeout_err` is retained.
- `initial_done`=0 in any state: at the next edge go to IDLE, clear all `reset_out` bits, `seq_done`, `cnt` and `cur_ch`. `timeout_err` is retained.
- `rst`=1: go to IDLE and clear all outputs, including `timeout_err`.
- Released channels stay released until an abort, a soft request or `rst`. There is no partial re-assertion.
- `soft_req` outside DONE is ignored, not queued.
- A `ch_ack` bit that is already high on entry to WAIT is accepted on the first WAIT cycle.
- A `ch_ack` bit for a channel other than `cur_ch` is ignored.

## Timing
- Reset values: `reset_out`=0, `seq_done`=0, `timeout_err`=0, `cur_ch`=0.
- Let E0 be the edge that samples `initial_done`=1 in IDLE.
- With `ACK_EN`=0:
  - `reset_out[i]` goes high at edge E0+(i+1)·DELAY;
  - `seq_done` goes high at the same edge as `reset_out[CH_NUM-1]`.
- With `ACK_EN`=1:
  - channel i+1 goes high DELAY edges after the edge on which `ch_ack[i]` is sampled high;
  - a timeout advances TIMEOUT edges after channel i's release.
- Soft request: `soft_req` sampled in DONE at edge S clears the outputs at S; `reset_out[0]` rises at S+DELAY.
- Abort latency is one edge. If `initial_done` falls on the same edge as a release would occur, the abort wins and no release happens.
- If `rst` and any other event occur together, `rst` wins.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- A shared package `reset_seq_pkg` holds:
  - the state enum (IDLE, HOLD, WAIT, DONE);
  - a clog2 constant function;
  - the default `DELAY` and `TIMEOUT` constants.
- No sub-module: the counter and the FSM form one block. Each downstream interface gets its own `reset_out` bit at the top level.

## Test plan
- Base sequence, `CH_NUM`=3, `DELAY`=4, `ACK_EN`=0: raise `initial_done` → `reset_out` goes 001 at E0+4, 011 at E0+8, 111 at E0+12; `seq_done`=1 at E0+12.
- Acknowledge stepping, `ACK_EN`=1, `TIMEOUT`=8: assert `ch_ack[0]` 3 cycles after `reset_out[0]` rises → `reset_out[1]` rises 4 edges after the acknowledge is sampled; `timeout_err` stays 0.
- Acknowledge timeout: hold `ch_ack[1]`=0 → `timeout_err`=1 exactly 8 edges after `reset_out[1]` rises, the sequence continues to channel 2, and `timeout_err` survives a later `initial_done` low/high cycle.
- Abort: drop `initial_done` at E0+6 → at the next edge `reset_out`=000, `cur_ch`=0, `seq_done`=0; raising it again restarts the full timing from the new E0.
- Soft request: pulse `soft_req` in DONE → `reset_out`=000 at the next edge, `reset_out[0]` rises 4 edges later; a pulse during HOLD has no effect.
- `rst` during WAIT with `timeout_err`=1 → all outputs 0 at the next edge, including `timeout_err`.
